// File: rtl/oscaler_sched.sv
// Channel sequencer: looks up per-channel scale/shift, issues psum vectors to the scaler, buffers results.
// Latency: issue at t, result visible on out_* during t+2 (scaler register + 2-entry buffer).
// Backpressure: in_ready is credit based; buffer plus in-flight never exceed 2, so out_ready=0 stalls after 2 issues.
module oscaler_sched #(
  parameter int numElements  = 4,
  parameter int elementWidth = 20,
  parameter int outputWidth  = 8,
  parameter int scaleWidth   = 16,
  parameter int shiftWidth   = 5,
  parameter int numChannels  = 16,
  localparam int chW = $clog2(numChannels)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_we,
  input  logic [chW-1:0]                      cfg_addr,
  input  logic [scaleWidth-1:0]               cfg_scale,
  input  logic [shiftWidth-1:0]               cfg_shift,
  input  logic                                start,
  input  logic [chW:0]                        num_ch,
  output logic                                busy,
  output logic                                done,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [numElements*elementWidth-1:0] in_wx,
  output logic [numElements*elementWidth-1:0] sc_wx,
  output logic [scaleWidth-1:0]               sc_scale,
  output logic [shiftWidth-1:0]               sc_shift,
  input  logic [numElements*outputWidth-1:0]  sc_y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [numElements*outputWidth-1:0]  out_y,
  output logic [chW-1:0]                      out_ch
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int YW = numElements*outputWidth;

  logic [scaleWidth-1:0] scale_tab [numChannels];
  logic [shiftWidth-1:0] shift_tab [numChannels];

  logic [1:0]     state;
  logic [chW-1:0] ch;
  logic [chW:0]   num_q;
  logic           zero_done;
  logic           inflight;
  logic [chW-1:0] tag;

  logic [YW-1:0]  buf_y  [2];
  logic [chW-1:0] buf_ch [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     count;

  logic       pop;
  logic       issue;
  logic       last_issue;
  logic       drain_done;
  logic [2:0] occ;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  // Occupancy seen by the next issue: a pop this cycle frees a slot in time for it.
  assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign in_ready  = (state == RUN) && (occ < 3'd2);
  assign issue     = in_valid & in_ready;
  assign last_issue = issue && (({1'b0, ch} + 1'b1) == num_q);

  assign drain_done = (state == DRAIN) && !inflight && (count == 2'd0);
  assign done       = zero_done | drain_done;
  assign busy       = (state != IDLE) && !drain_done;

  assign sc_wx    = issue ? in_wx : '0;
  assign sc_scale = issue ? scale_tab[ch] : '0;
  assign sc_shift = issue ? shift_tab[ch] : '0;

  assign out_y  = buf_y[rd_ptr];
  assign out_ch = buf_ch[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < numChannels; i++) begin
        scale_tab[i] <= '0;
        shift_tab[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      scale_tab[cfg_addr] <= cfg_scale;
      shift_tab[cfg_addr] <= cfg_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      num_q     <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_ch != '0) begin
              num_q <= num_ch;
              ch    <= '0;
              state <= RUN;
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            ch <= ch + 1'b1;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The scaler registers its result, so capture sc_y one cycle after the issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      tag      <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_y[i]  <= '0;
        buf_ch[i] <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) tag <= ch;
      if (inflight) begin
        buf_y[wr_ptr]  <= sc_y;
        buf_ch[wr_ptr] <= tag;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_oscaler_sched.sv
// Scoreboard bench for oscaler_sched with a registered scaler stub and a channel-table reference model.
module tb_oscaler_sched;
  localparam int NE = 4, EW = 20, OW = 8, SW = 16, HW = 5, NC = 16, CW = 4;

  logic clk, rst;
  logic cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [SW-1:0] cfg_scale;
  logic [HW-1:0] cfg_shift;
  logic start;
  logic [CW:0] num_ch;
  logic busy, done;
  logic in_valid, in_ready;
  logic [NE*EW-1:0] in_wx, sc_wx;
  logic [SW-1:0] sc_scale;
  logic [HW-1:0] sc_shift;
  logic [NE*OW-1:0] sc_y;
  logic out_valid, out_ready;
  logic [NE*OW-1:0] out_y;
  logic [CW-1:0] out_ch;

  oscaler_sched dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .start(start), .num_ch(num_ch), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_wx(in_wx),
    .sc_wx(sc_wx), .sc_scale(sc_scale), .sc_shift(sc_shift), .sc_y(sc_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_ch(out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requantization: product of lane and scale, scaled down by 2^(28+shift), low byte kept.
  function automatic logic [OW-1:0] scaled(input logic [EW-1:0] wx, input logic [SW-1:0] s,
                                           input logic [HW-1:0] sh);
    longint unsigned p;
    p = longint'(wx) * longint'(s);
    p = p >> (28 + int'(sh));
    return p[OW-1:0];
  endfunction

  always @(posedge clk)
    for (int i = 0; i < NE; i++)
      sc_y[i*OW +: OW] <= scaled(sc_wx[i*EW +: EW], sc_scale, sc_shift);

  int tests = 0, fails = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = -1, last_pop_cyc = -1, pops = 0;
  int first_issue_cyc = -1, first_valid_cyc = -1;
  bit first_armed = 0;

  logic [SW-1:0] m_scale [NC];
  logic [HW-1:0] m_shift [NC];
  bit in_pass = 0;
  int pass_ch = 0;
  int ready_mode = 1;
  bit use_fixed = 0;
  logic [EW-1:0] fixed_lane = 20'h40000;

  logic [NE*OW-1:0] q_y [$];
  logic [CW-1:0]    q_ch [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q_y.size() == 0) begin
          chk("unexpected_output", 64'(out_ch), 64'hFFFF);
        end else begin
          chk("out_y", 64'(out_y), 64'(q_y[0]));
          chk("out_ch", 64'(out_ch), 64'(q_ch[0]));
          void'(q_y.pop_front());
          void'(q_ch.pop_front());
        end
        last_pop_cyc = cyc;
        pops++;
      end
      if (out_valid && first_armed) begin
        first_valid_cyc = cyc;
        first_armed = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    start = 1'b0;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic cfg_write(input int a, input logic [SW-1:0] s, input logic [HW-1:0] h);
    tick();
    cfg_we = 1'b1;
    cfg_addr = CW'(a);
    cfg_scale = s;
    cfg_shift = h;
    if (!in_pass) begin
      m_scale[a] = s;
      m_shift[a] = h;
    end
  endtask

  task automatic start_pass(input int n);
    tick();
    start = 1'b1;
    num_ch = (CW+1)'(n);
    pass_ch = 0;
    in_pass = (n != 0);
  endtask

  task automatic feed(input int n, input int max_cyc, input bit rand_valid);
    int k = 0;
    logic [NE*OW-1:0] ey;
    while (pass_ch < n && k < max_cyc) begin
      tick();
      in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int i = 0; i < NE; i++)
        in_wx[i*EW +: EW] = use_fixed ? fixed_lane : EW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        for (int i = 0; i < NE; i++)
          ey[i*OW +: OW] = scaled(in_wx[i*EW +: EW], m_scale[pass_ch], m_shift[pass_ch]);
        q_y.push_back(ey);
        q_ch.push_back(CW'(pass_ch));
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        pass_ch++;
      end
      k++;
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    bit got = 0;
    while (!got && k < budget) begin
      tick();
      @(negedge clk);
      if (done) got = 1;
      k++;
    end
    chk("done_timeout", 64'(got), 64'd1);
    in_pass = 0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, p0, n;
    rst = 1'b1;
    cfg_we = 0; cfg_addr = '0; cfg_scale = '0; cfg_shift = '0;
    start = 0; num_ch = '0; in_valid = 0; in_wx = '0; out_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin m_scale[i] = '0; m_shift[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_y", 64'(out_y), 0);
    chk("rst_out_ch", 64'(out_ch), 0);
    chk("rst_sc_wx", 64'(sc_wx), 0);
    chk("rst_sc_scale", 64'(sc_scale), 0);
    chk("rst_sc_shift", 64'(sc_shift), 0);
    tick();
    rst = 1'b0;

    // Full-rate pass with all four channels at scale 0x4000 / shift 1
    use_fixed = 1;
    ready_mode = 1;
    for (int c = 0; c < 4; c++) cfg_write(c, 16'h4000, 5'd1);
    d0 = done_cnt; p0 = pops;
    first_armed = 1; first_issue_cyc = -1;
    start_pass(4);
    feed(4, 20, 0);
    wait_done(30);
    chk("first_valid_latency", 64'(first_valid_cyc - first_issue_cyc), 64'd2);
    chk("tp_pops", 64'(pops - p0), 64'd4);
    chk("tp_back_to_back", 64'(last_pop_cyc - first_valid_cyc), 64'd3);
    chk("tp_done_after_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
    chk("tp_done_count", 64'(done_cnt - d0), 64'd1);
    chk("tp_queue_empty", 64'(q_y.size()), 64'd0);

    // Stalled output: only two issues fit, head holds steady
    ready_mode = 0;
    d0 = done_cnt; p0 = pops;
    start_pass(4);
    feed(4, 8, 0);
    chk("bp_issues", 64'(pass_ch), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head_y", 64'(out_y), 64'(q_y[0]));
    chk("bp_head_ch", 64'(out_ch), 64'(q_ch[0]));
    repeat (3) tick();
    @(negedge clk);
    chk("bp_hold_y", 64'(out_y), 64'(q_y[0]));
    chk("bp_hold_ch", 64'(out_ch), 64'(q_ch[0]));
    chk("bp_still_stalled", 64'(in_ready), 64'd0);
    ready_mode = 1;
    feed(4, 20, 0);
    wait_done(30);
    chk("bp_pops", 64'(pops - p0), 64'd4);
    chk("bp_done_count", 64'(done_cnt - d0), 64'd1);
    chk("bp_queue_empty", 64'(q_y.size()), 64'd0);

    // Zero-length pass
    d0 = done_cnt;
    tick();
    start = 1'b1;
    num_ch = '0;
    @(negedge clk);
    chk("z_done_before", 64'(done), 0);
    tick();
    @(negedge clk);
    chk("z_done_pulse", 64'(done), 1);
    chk("z_busy", 64'(busy), 0);
    chk("z_in_ready", 64'(in_ready), 0);
    tick();
    @(negedge clk);
    chk("z_done_single", 64'(done), 0);
    chk("z_busy_after", 64'(busy), 0);
    chk("z_in_ready_after", 64'(in_ready), 0);
    chk("z_done_count", 64'(done_cnt - d0), 64'd1);

    // Table write during a pass is dropped; the same write afterwards lands
    start_pass(4);
    cfg_write(1, 16'h8000, 5'd1);
    feed(4, 20, 0);
    wait_done(30);
    cfg_write(1, 16'h8000, 5'd1);
    start_pass(4);
    feed(4, 20, 0);
    wait_done(30);
    chk("cfg_queue_empty", 64'(q_y.size()), 64'd0);

    // A second start while running changes nothing
    d0 = done_cnt; p0 = pops;
    start_pass(4);
    feed(2, 20, 0);
    tick();
    start = 1'b1;
    num_ch = 5'd1;
    feed(4, 20, 0);
    wait_done(30);
    chk("sr_done_count", 64'(done_cnt - d0), 64'd1);
    chk("sr_pops", 64'(pops - p0), 64'd4);
    repeat (5) tick();
    @(negedge clk);
    chk("sr_no_extra_done", 64'(done_cnt - d0), 64'd1);
    chk("sr_idle_busy", 64'(busy), 0);
    chk("sr_idle_in_ready", 64'(in_ready), 0);

    // Random tables, lengths, valid and ready patterns
    use_fixed = 0;
    for (int p = 0; p < 6; p++) begin
      ready_mode = 1;
      for (int c = 0; c < NC; c++)
        cfg_write(c, SW'($urandom), HW'($urandom_range(0, 3)));
      n = $urandom_range(1, NC);
      d0 = done_cnt; p0 = pops;
      ready_mode = 2;
      start_pass(n);
      feed(n, 400, 1);
      wait_done(400);
      chk("rnd_issues", 64'(pass_ch), 64'(n));
      chk("rnd_pops", 64'(pops - p0), 64'(n));
      chk("rnd_done_after_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
      chk("rnd_done_count", 64'(done_cnt - d0), 64'd1);
    end

    // Reset with one result buffered, then confirm the table was cleared
    ready_mode = 0;
    start_pass(4);
    feed(1, 10, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("mr_buffered", 64'(out_valid), 64'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", 64'(out_valid), 0);
    chk("mr_in_ready", 64'(in_ready), 0);
    chk("mr_busy", 64'(busy), 0);
    chk("mr_done", 64'(done), 0);
    chk("mr_out_y", 64'(out_y), 0);
    q_y.delete();
    q_ch.delete();
    for (int i = 0; i < NC; i++) begin m_scale[i] = '0; m_shift[i] = '0; end
    in_pass = 0;
    tick();
    rst = 1'b0;
    ready_mode = 1;
    p0 = pops;
    start_pass(2);
    feed(2, 20, 0);
    wait_done(30);
    chk("mr_pops", 64'(pops - p0), 64'd2);
    chk("mr_queue_empty", 64'(q_y.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
